// File: rtl/tlb_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : tlb_ctrl_if
// Purpose : Op request and CSR write-back bundle between WB stage and tlb_ctrl.
// Rev     : 1.0
// ============================================================================

interface tlb_ctrl_if #(
   parameter int TLBNUM = 16
);
   localparam int IW = $clog2(TLBNUM);

   logic          op_valid;
   logic          op_ready;
   logic [2:0]    op_code;
   logic [4:0]    inv_op;
   logic [9:0]    inv_asid;
   logic [18:0]   inv_vppn;
   logic [IW-1:0] csr_index;
   logic          csr_ne;
   logic [5:0]    csr_ps;
   logic [18:0]   csr_vppn;
   logic [9:0]    csr_asid;
   logic [31:0]   csr_elo0;
   logic [31:0]   csr_elo1;
   logic [5:0]    csr_ecode;

   logic          done;
   logic          done_ine;
   logic          wb_idx_we;
   logic          wb_ne_we;
   logic          wb_ehi_we;
   logic [IW-1:0] wb_index;
   logic          wb_ne;
   logic [5:0]    wb_ps;
   logic [18:0]   wb_vppn;
   logic [9:0]    wb_asid;
   logic [31:0]   wb_elo0;
   logic [31:0]   wb_elo1;

   modport master (
      output op_valid, op_code, inv_op, inv_asid, inv_vppn, csr_index, csr_ne,
             csr_ps, csr_vppn, csr_asid, csr_elo0, csr_elo1, csr_ecode,
      input  op_ready, done, done_ine, wb_idx_we, wb_ne_we, wb_ehi_we, wb_index,
             wb_ne, wb_ps, wb_vppn, wb_asid, wb_elo0, wb_elo1
   );

   modport slave (
      input  op_valid, op_code, inv_op, inv_asid, inv_vppn, csr_index, csr_ne,
             csr_ps, csr_vppn, csr_asid, csr_elo0, csr_elo1, csr_ecode,
      output op_ready, done, done_ine, wb_idx_we, wb_ne_we, wb_ehi_we, wb_index,
             wb_ne, wb_ps, wb_vppn, wb_asid, wb_elo0, wb_elo1
   );
endinterface

`default_nettype wire

// File: rtl/tlb_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tlb_ctrl
// Purpose : Three-cycle sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB.
// Rev     : 1.0
// ============================================================================

module tlb_ctrl #(
   parameter  int TLBNUM = 16,
   localparam int IW     = $clog2(TLBNUM)
) (
   input  logic          clk,
   input  logic          reset,
   tlb_ctrl_if.slave     op,
   output logic          s1_sel,
   output logic [18:0]   s1_vppn,
   output logic [9:0]    s1_asid,
   output logic          s1_va_bit12,
   input  logic          s1_found,
   input  logic [IW-1:0] s1_index,
   output logic          we,
   output logic [IW-1:0] w_index,
   output logic          w_e,
   output logic [18:0]   w_vppn,
   output logic [5:0]    w_ps,
   output logic [9:0]    w_asid,
   output logic          w_g,
   output logic [19:0]   w_ppn0, w_ppn1,
   output logic [1:0]    w_plv0, w_plv1, w_mat0, w_mat1,
   output logic          w_d0, w_d1, w_v0, w_v1,
   output logic [IW-1:0] r_index,
   input  logic          r_e,
   input  logic [18:0]   r_vppn,
   input  logic [5:0]    r_ps,
   input  logic [9:0]    r_asid,
   input  logic          r_g,
   input  logic [19:0]   r_ppn0, r_ppn1,
   input  logic [1:0]    r_plv0, r_plv1, r_mat0, r_mat1,
   input  logic          r_d0, r_d1, r_v0, r_v1,
   output logic          invtlb_valid,
   output logic [4:0]    invtlb_op
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [2:0]    OP_SRCH  = 3'd0;
   localparam logic [2:0]    OP_RD    = 3'd1;
   localparam logic [2:0]    OP_WR    = 3'd2;
   localparam logic [2:0]    OP_FILL  = 3'd3;
   localparam logic [2:0]    OP_INV   = 3'd4;
   localparam logic [IW-1:0] FILL_MAX = IW'(TLBNUM - 1);

   typedef struct packed {
      logic [2:0]    code;
      logic [4:0]    inv_op;
      logic [9:0]    inv_asid;
      logic [18:0]   inv_vppn;
      logic [IW-1:0] index;
      logic          ne;
      logic [5:0]    ps;
      logic [18:0]   vppn;
      logic [9:0]    asid;
      logic [31:0]   elo0;
      logic [31:0]   elo1;
      logic [5:0]    ecode;
      logic [IW-1:0] fill_idx;
   } op_regs_t;

   typedef struct packed {
      logic          ine;
      logic          idx_we;
      logic          ne_we;
      logic          ehi_we;
      logic [IW-1:0] index;
      logic          ne;
      logic [5:0]    ps;
      logic [18:0]   vppn;
      logic [9:0]    asid;
      logic [31:0]   elo0;
      logic [31:0]   elo1;
   } wb_regs_t;

   state_t        state_q, state_d;
   logic [IW-1:0] fill_ctr_q, fill_ctr_d;
   op_regs_t      op_q, op_d;
   wb_regs_t      wb_q, wb_d;

   logic          is_issue, is_srch, is_rd, is_inv;
   logic [31:0]   elo0_m, elo1_m;
   logic          unused_elo_bits;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         fill_ctr_q <= '0;
         op_q       <= '0;
         wb_q       <= '0;
      end else begin
         state_q    <= state_d;
         fill_ctr_q <= fill_ctr_d;
         op_q       <= op_d;
         wb_q       <= wb_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      fill_ctr_d = (fill_ctr_q == FILL_MAX) ? '0 : fill_ctr_q + 1'b1;
      case (state_q)
         S_IDLE: begin
            if (op.op_valid) begin
               state_d = S_ISSUE;
               op_d    = '{code: op.op_code, inv_op: op.inv_op, inv_asid: op.inv_asid,
                           inv_vppn: op.inv_vppn, index: op.csr_index, ne: op.csr_ne,
                           ps: op.csr_ps, vppn: op.csr_vppn, asid: op.csr_asid,
                           elo0: op.csr_elo0, elo1: op.csr_elo1, ecode: op.csr_ecode,
                           fill_idx: fill_ctr_q};
            end
         end
         S_ISSUE: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // Array ports are gated by reset so an op aborted mid-ISSUE never pulses.
   always_comb begin
      is_issue     = (state_q == S_ISSUE) && !reset;
      is_srch      = is_issue && (op_q.code == OP_SRCH);
      is_rd        = is_issue && (op_q.code == OP_RD);
      is_inv       = is_issue && (op_q.code == OP_INV);
      we           = is_issue && ((op_q.code == OP_WR) || (op_q.code == OP_FILL));
      s1_sel       = is_srch || is_inv;
      s1_vppn      = is_srch ? op_q.vppn : (is_inv ? op_q.inv_vppn : '0);
      s1_asid      = is_srch ? op_q.asid : (is_inv ? op_q.inv_asid : '0);
      s1_va_bit12  = 1'b0;
      invtlb_op    = is_inv ? op_q.inv_op : '0;
      invtlb_valid = is_inv && (op_q.inv_op <= 5'd6);
      r_index      = is_rd ? op_q.index : '0;
      elo0_m       = we ? op_q.elo0 : '0;
      elo1_m       = we ? op_q.elo1 : '0;
      w_index      = !we ? '0 : ((op_q.code == OP_FILL) ? op_q.fill_idx : op_q.index);
      w_e          = we && ((op_q.ecode == 6'h3F) || !op_q.ne);
      w_vppn       = we ? op_q.vppn : '0;
      w_ps         = we ? op_q.ps   : '0;
      w_asid       = we ? op_q.asid : '0;
      w_g          = elo0_m[6] & elo1_m[6];
      w_ppn0       = elo0_m[27:8];
      w_ppn1       = elo1_m[27:8];
      w_mat0       = elo0_m[5:4];
      w_mat1       = elo1_m[5:4];
      w_plv0       = elo0_m[3:2];
      w_plv1       = elo1_m[3:2];
      w_d0         = elo0_m[1];
      w_d1         = elo1_m[1];
      w_v0         = elo0_m[0];
      w_v1         = elo1_m[0];
   end

   assign unused_elo_bits = ^{elo0_m[31:28], elo0_m[7], elo1_m[31:28], elo1_m[7]};

   // Search/read results are captured at the end of ISSUE and held through DONE.
   always_comb begin
      wb_d = '0;
      if (is_issue) begin
         case (op_q.code)
            OP_SRCH: begin
               wb_d.ne_we  = 1'b1;
               wb_d.idx_we = s1_found;
               wb_d.ne     = !s1_found;
               wb_d.index  = s1_found ? s1_index : '0;
            end
            OP_RD: begin
               wb_d.ne_we  = 1'b1;
               wb_d.ehi_we = 1'b1;
               wb_d.ne     = !r_e;
               if (r_e) begin
                  wb_d.ps   = r_ps;
                  wb_d.vppn = r_vppn;
                  wb_d.asid = r_asid;
                  wb_d.elo0 = {4'b0, r_ppn0, 1'b0, r_g, r_mat0, r_plv0, r_d0, r_v0};
                  wb_d.elo1 = {4'b0, r_ppn1, 1'b0, r_g, r_mat1, r_plv1, r_d1, r_v1};
               end
            end
            OP_INV:  wb_d.ine = (op_q.inv_op > 5'd6);
            default: ;
         endcase
      end
   end

   assign op.op_ready  = (state_q == S_IDLE);
   assign op.done      = (state_q == S_DONE);
   assign op.done_ine  = wb_q.ine;
   assign op.wb_idx_we = wb_q.idx_we;
   assign op.wb_ne_we  = wb_q.ne_we;
   assign op.wb_ehi_we = wb_q.ehi_we;
   assign op.wb_index  = wb_q.index;
   assign op.wb_ne     = wb_q.ne;
   assign op.wb_ps     = wb_q.ps;
   assign op.wb_vppn   = wb_q.vppn;
   assign op.wb_asid   = wb_q.asid;
   assign op.wb_elo0   = wb_q.elo0;
   assign op.wb_elo1   = wb_q.elo1;

endmodule

`default_nettype wire

// File: tb/tb_tlb_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_tlb_ctrl
// Purpose : Scoreboard bench for tlb_ctrl with a behavioural 16-entry TLB array.
// Rev     : 1.0
// ============================================================================

module tb_tlb_ctrl;
   localparam int TLBNUM = 16;
   localparam int IW     = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   tlb_ctrl_if #(.TLBNUM(TLBNUM)) bus();

   logic          s1_sel, s1_va_bit12, s1_found, we, w_e, w_g;
   logic [18:0]   s1_vppn, w_vppn;
   logic [9:0]    s1_asid, w_asid;
   logic [IW-1:0] s1_index, w_index, r_index;
   logic [5:0]    w_ps;
   logic [19:0]   w_ppn0, w_ppn1;
   logic [1:0]    w_plv0, w_plv1, w_mat0, w_mat1;
   logic          w_d0, w_d1, w_v0, w_v1;
   logic          r_e, r_g, r_d0, r_d1, r_v0, r_v1;
   logic [18:0]   r_vppn;
   logic [5:0]    r_ps;
   logic [9:0]    r_asid;
   logic [19:0]   r_ppn0, r_ppn1;
   logic [1:0]    r_plv0, r_plv1, r_mat0, r_mat1;
   logic          invtlb_valid;
   logic [4:0]    invtlb_op;

   tlb_ctrl #(.TLBNUM(TLBNUM)) dut (
      .clk(clk), .reset(reset), .op(bus),
      .s1_sel(s1_sel), .s1_vppn(s1_vppn), .s1_asid(s1_asid), .s1_va_bit12(s1_va_bit12),
      .s1_found(s1_found), .s1_index(s1_index),
      .we(we), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps),
      .w_asid(w_asid), .w_g(w_g), .w_ppn0(w_ppn0), .w_ppn1(w_ppn1),
      .w_plv0(w_plv0), .w_plv1(w_plv1), .w_mat0(w_mat0), .w_mat1(w_mat1),
      .w_d0(w_d0), .w_d1(w_d1), .w_v0(w_v0), .w_v1(w_v1),
      .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid),
      .r_g(r_g), .r_ppn0(r_ppn0), .r_ppn1(r_ppn1), .r_plv0(r_plv0), .r_plv1(r_plv1),
      .r_mat0(r_mat0), .r_mat1(r_mat1), .r_d0(r_d0), .r_d1(r_d1), .r_v0(r_v0), .r_v1(r_v1),
      .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op)
   );

   // Behavioural TLB array: combinational search/read, write and INVTLB op 5 on the clock.
   logic          e_m    [TLBNUM];
   logic          g_m    [TLBNUM];
   logic [18:0]   vppn_m [TLBNUM];
   logic [9:0]    asid_m [TLBNUM];
   logic [5:0]    ps_m   [TLBNUM];
   logic [19:0]   ppn0_m [TLBNUM];
   logic [19:0]   ppn1_m [TLBNUM];
   logic [1:0]    plv0_m [TLBNUM];
   logic [1:0]    plv1_m [TLBNUM];
   logic [1:0]    mat0_m [TLBNUM];
   logic [1:0]    mat1_m [TLBNUM];
   logic [3:0]    dv_m   [TLBNUM];

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TLBNUM; i++) begin
            e_m[i] <= 1'b0; g_m[i] <= 1'b0; vppn_m[i] <= '0; asid_m[i] <= '0;
            ps_m[i] <= '0; ppn0_m[i] <= '0; ppn1_m[i] <= '0; plv0_m[i] <= '0;
            plv1_m[i] <= '0; mat0_m[i] <= '0; mat1_m[i] <= '0; dv_m[i] <= '0;
         end
      end else begin
         if (we) begin
            e_m[w_index] <= w_e;       g_m[w_index] <= w_g;
            vppn_m[w_index] <= w_vppn; asid_m[w_index] <= w_asid;
            ps_m[w_index] <= w_ps;     ppn0_m[w_index] <= w_ppn0;
            ppn1_m[w_index] <= w_ppn1; plv0_m[w_index] <= w_plv0;
            plv1_m[w_index] <= w_plv1; mat0_m[w_index] <= w_mat0;
            mat1_m[w_index] <= w_mat1; dv_m[w_index] <= {w_d0, w_v0, w_d1, w_v1};
         end
         if (invtlb_valid && invtlb_op == 5'd5) begin
            for (int i = 0; i < TLBNUM; i++)
               if (e_m[i] && !g_m[i] && asid_m[i] == s1_asid && vppn_m[i] == s1_vppn)
                  e_m[i] <= 1'b0;
         end
      end
   end

   always_comb begin
      s1_found = 1'b0;
      s1_index = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
         if (e_m[i] && vppn_m[i] == s1_vppn && (g_m[i] || asid_m[i] == s1_asid)) begin
            s1_found = 1'b1;
            s1_index = IW'(i);
         end
      end
   end

   assign r_e    = e_m[r_index];
   assign r_g    = g_m[r_index];
   assign r_vppn = vppn_m[r_index];
   assign r_asid = asid_m[r_index];
   assign r_ps   = ps_m[r_index];
   assign r_ppn0 = ppn0_m[r_index];
   assign r_ppn1 = ppn1_m[r_index];
   assign r_plv0 = plv0_m[r_index];
   assign r_plv1 = plv1_m[r_index];
   assign r_mat0 = mat0_m[r_index];
   assign r_mat1 = mat1_m[r_index];
   assign {r_d0, r_v0, r_d1, r_v1} = dv_m[r_index];

   typedef struct packed {
      logic s1_sel; logic [18:0] s1_vppn; logic [9:0] s1_asid; logic va12;
      logic we; logic [3:0] w_index; logic w_e; logic w_g; logic [19:0] w_ppn0;
      logic inv_v; logic [4:0] inv_op; logic [3:0] r_index;
   } iss_t;

   typedef struct packed {
      logic ine; logic idx_we; logic ne_we; logic ehi_we; logic [3:0] index; logic ne;
      logic [5:0] ps; logic [18:0] vppn; logic [9:0] asid; logic [31:0] elo0; logic [31:0] elo1;
   } done_t;

   iss_t  got_iss;
   done_t got_done;
   assign got_iss  = {s1_sel, s1_vppn, s1_asid, s1_va_bit12, we, w_index, w_e, w_g,
                      w_ppn0, invtlb_valid, invtlb_op, r_index};
   assign got_done = {bus.done_ine, bus.wb_idx_we, bus.wb_ne_we, bus.wb_ehi_we, bus.wb_index,
                      bus.wb_ne, bus.wb_ps, bus.wb_vppn, bus.wb_asid, bus.wb_elo0, bus.wb_elo1};

   int    n_tests = 0;
   int    n_fail  = 0;
   iss_t  iss_q[$];
   done_t done_q[$];
   string iss_n[$];
   string done_n[$];

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   function automatic iss_t x_wr(input logic [3:0] idx, input logic e, input logic g,
                                 input logic [19:0] ppn);
      iss_t x = '0;
      x.we = 1'b1; x.w_index = idx; x.w_e = e; x.w_g = g; x.w_ppn0 = ppn;
      return x;
   endfunction

   function automatic iss_t x_srch(input logic [18:0] v, input logic [9:0] a);
      iss_t x = '0;
      x.s1_sel = 1'b1; x.s1_vppn = v; x.s1_asid = a;
      return x;
   endfunction

   function automatic iss_t x_inv(input logic [18:0] v, input logic [9:0] a,
                                  input logic [4:0] o, input logic pulse);
      iss_t x = '0;
      x.s1_sel = 1'b1; x.s1_vppn = v; x.s1_asid = a; x.inv_op = o; x.inv_v = pulse;
      return x;
   endfunction

   function automatic iss_t x_rd(input logic [3:0] idx);
      iss_t x = '0;
      x.r_index = idx;
      return x;
   endfunction

   function automatic done_t d_srch(input logic hit, input logic [3:0] idx);
      done_t d = '0;
      d.ne_we = 1'b1; d.idx_we = hit; d.index = idx; d.ne = !hit;
      return d;
   endfunction

   function automatic done_t d_rd(input logic ne, input logic [5:0] ps, input logic [18:0] v,
                                  input logic [9:0] a, input logic [31:0] e0, input logic [31:0] e1);
      done_t d = '0;
      d.ne_we = 1'b1; d.ehi_we = 1'b1; d.ne = ne; d.ps = ps; d.vppn = v; d.asid = a;
      d.elo0 = e0; d.elo1 = e1;
      return d;
   endfunction

   function automatic done_t d_none(input logic ine);
      done_t d = '0;
      d.ine = ine;
      return d;
   endfunction

   task automatic set_csr(input logic [3:0] idx, input logic ne, input logic [5:0] ps,
                          input logic [18:0] v, input logic [9:0] a, input logic [31:0] e0,
                          input logic [31:0] e1, input logic [5:0] ec);
      bus.csr_index = idx; bus.csr_ne = ne; bus.csr_ps = ps; bus.csr_vppn = v;
      bus.csr_asid = a; bus.csr_elo0 = e0; bus.csr_elo1 = e1; bus.csr_ecode = ec;
   endtask

   task automatic set_inv(input logic [4:0] o, input logic [9:0] a, input logic [18:0] v);
      bus.inv_op = o; bus.inv_asid = a; bus.inv_vppn = v;
   endtask

   task automatic go(input string nm, input logic [2:0] code, input iss_t ei, input done_t ed);
      iss_q.push_back(ei);
      iss_n.push_back(nm);
      done_q.push_back(ed);
      done_n.push_back(nm);
      bus.op_code  = code;
      bus.op_valid = 1'b1;
      @(posedge clk); #1;
      bus.op_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
   endtask

   // Phase tracker: ISSUE follows an accept edge, DONE follows ISSUE.
   logic ph_iss = 1'b0;
   logic ph_done = 1'b0;
   always @(posedge clk) begin
      if (reset) begin
         ph_iss  <= 1'b0;
         ph_done <= 1'b0;
      end else begin
         ph_iss  <= bus.op_valid && bus.op_ready;
         ph_done <= ph_iss;
      end
   end

   iss_t  mon_ei;
   done_t mon_ed;
   string mon_nm;
   initial begin
      forever begin
         @(negedge clk);
         if (ph_iss) begin
            if (iss_q.size() > 0) begin
               mon_ei = iss_q.pop_front();
               mon_nm = iss_n.pop_front();
               chk({mon_nm, "_issue"}, 128'(got_iss), 128'(mon_ei));
            end else begin
               chk("unqueued_issue_pulses", {125'd0, we, invtlb_valid, s1_sel}, 128'd0);
            end
         end else if (we || invtlb_valid || s1_sel) begin
            chk("stray_array_pulse", {125'd0, we, invtlb_valid, s1_sel}, 128'd0);
         end
         if (ph_done) begin
            if (done_q.size() > 0) begin
               mon_ed = done_q.pop_front();
               mon_nm = done_n.pop_front();
               chk({mon_nm, "_done_strobe"}, 128'(bus.done), 128'd1);
               chk({mon_nm, "_wb"}, 128'(got_done), 128'(mon_ed));
            end else begin
               chk("unqueued_done", 128'(bus.done), 128'd0);
            end
         end else if (bus.done) begin
            chk("stray_done", 128'(bus.done), 128'd0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.op_valid = 1'b0;
      bus.op_code  = 3'd0;
      set_inv(5'd0, 10'd0, 19'd0);
      set_csr(4'd0, 1'b0, 6'd0, 19'd0, 10'd0, 32'd0, 32'd0, 6'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_op_ready", 128'(bus.op_ready), 128'd1);
      chk("rst_done", 128'(bus.done), 128'd0);
      chk("rst_ports", {125'd0, we, invtlb_valid, s1_sel}, 128'd0);
      chk("rst_wb_enables", {124'd0, bus.done_ine, bus.wb_idx_we, bus.wb_ne_we, bus.wb_ehi_we}, 128'd0);
      reset = 1'b0;

      // Accept lands on the 8th edge after reset: fill counter holds 7.
      repeat (7) @(posedge clk);
      #1;
      set_csr(4'd2, 1'b1, 6'd12, 19'h00777, 10'd3, 32'h0123455F, 32'h00000041, 6'h3F);
      go("fill_idx7", 3'd3, x_wr(4'd7, 1'b1, 1'b1, 20'h12345), d_none(1'b0));
      set_csr(4'd5, 1'b0, 6'd12, 19'h01234, 10'd3, 32'h0ABCDE01, 32'h00000000, 6'h00);
      go("wr_idx5", 3'd2, x_wr(4'd5, 1'b1, 1'b0, 20'hABCDE), d_none(1'b0));
      go("srch_hit5", 3'd0, x_srch(19'h01234, 10'd3), d_srch(1'b1, 4'd5));
      // Nine edges later the counter has wrapped 15 -> 0.
      set_csr(4'd5, 1'b0, 6'd12, 19'h04444, 10'd3, 32'h00000001, 32'h00000000, 6'h00);
      go("fill_wrap0", 3'd3, x_wr(4'd0, 1'b1, 1'b0, 20'h00000), d_none(1'b0));

      set_csr(4'd5, 1'b0, 6'd0, 19'd0, 10'd0, 32'd0, 32'd0, 6'd0);
      go("rd_idx5", 3'd1, x_rd(4'd5),
         d_rd(1'b0, 6'd12, 19'h01234, 10'd3, 32'h0ABCDE01, 32'h00000000));
      set_csr(4'd9, 1'b1, 6'd12, 19'h00999, 10'd3, 32'h0FFFFF03, 32'h00000000, 6'h00);
      go("wr_ne_invalid", 3'd2, x_wr(4'd9, 1'b0, 1'b0, 20'hFFFFF), d_none(1'b0));
      set_csr(4'd9, 1'b0, 6'd0, 19'd0, 10'd0, 32'd0, 32'd0, 6'd0);
      go("rd_invalid9", 3'd1, x_rd(4'd9), d_rd(1'b1, 6'd0, 19'd0, 10'd0, 32'd0, 32'd0));

      set_inv(5'd5, 10'd3, 19'h01234);
      go("inv_op5", 3'd4, x_inv(19'h01234, 10'd3, 5'd5, 1'b1), d_none(1'b0));
      set_csr(4'd0, 1'b0, 6'd0, 19'h01234, 10'd3, 32'd0, 32'd0, 6'd0);
      go("srch_miss_after_inv", 3'd0, x_srch(19'h01234, 10'd3), d_srch(1'b0, 4'd0));
      set_csr(4'd0, 1'b0, 6'd0, 19'h00777, 10'd9, 32'd0, 32'd0, 6'd0);
      go("srch_global7", 3'd0, x_srch(19'h00777, 10'd9), d_srch(1'b1, 4'd7));
      set_inv(5'd7, 10'd3, 19'h00777);
      go("inv_op7_ine", 3'd4, x_inv(19'h00777, 10'd3, 5'd7, 1'b0), d_none(1'b1));
      set_inv(5'd6, 10'd1, 19'h00000);
      go("inv_op6_edge", 3'd4, x_inv(19'h00000, 10'd1, 5'd6, 1'b1), d_none(1'b0));
      set_csr(4'd5, 1'b0, 6'd12, 19'h01234, 10'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'h3F);
      go("nop_code6", 3'd6, iss_t'('0), d_none(1'b0));

      // op_valid held through ISSUE and DONE must yield a single operation.
      set_csr(4'd0, 1'b0, 6'd0, 19'h04444, 10'd3, 32'd0, 32'd0, 6'd0);
      iss_q.push_back(x_srch(19'h04444, 10'd3));
      iss_n.push_back("held_srch");
      done_q.push_back(d_srch(1'b1, 4'd0));
      done_n.push_back("held_srch");
      bus.op_code  = 3'd0;
      bus.op_valid = 1'b1;
      @(posedge clk); #1;
      chk("held_ready_issue", 128'(bus.op_ready), 128'd0);
      @(posedge clk); #1;
      chk("held_ready_done", 128'(bus.op_ready), 128'd0);
      bus.op_valid = 1'b0;
      @(posedge clk); #1;

      // Reset during ISSUE of a WR: no write pulse, no done.
      set_csr(4'd3, 1'b0, 6'd12, 19'h00333, 10'd3, 32'h00000001, 32'd0, 6'h00);
      bus.op_code  = 3'd2;
      bus.op_valid = 1'b1;
      @(posedge clk); #1;
      bus.op_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort_op_ready", 128'(bus.op_ready), 128'd1);
      chk("abort_done", 128'(bus.done), 128'd0);
      repeat (4) @(posedge clk);
      #1;
      chk("iss_queue_drained", 128'(iss_q.size()), 128'd0);
      chk("done_queue_drained", 128'(done_q.size()), 128'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
